alarm_snooze_ctrl: RTL and testbench



---
 rtl/alarm_snooze_ctrl_pkg.sv | 26 ++
 rtl/alarm_snooze_ctrl_if.sv | 32 +++
 rtl/alarm_snooze_ctrl_sec_downcounter.sv | 33 +++
 rtl/alarm_snooze_ctrl.sv | 123 ++++++++++++
 tb/tb_alarm_snooze_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alarm_snooze_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alarm_pkg
// Brief   : Shared state encoding, day constants and width helper for the
//           alarm snooze controller.
// Revision: 1.0 - initial release
// ============================================================================
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2,
      DONE   = 2'd3
   } alarm_state_t;

   localparam logic [2:0] DAY_SUN = 3'd0;
   localparam logic [2:0] DAY_SAT = 3'd6;

   // Counter widths must never collapse to zero bits.
   function automatic int min1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_snooze_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : alarm_snooze_ctrl_if
// Brief   : Comparator/button inputs and buzzer/status outputs of the alarm
//           snooze controller.
// Revision: 1.0 - initial release
// ============================================================================
interface alarm_snooze_ctrl_if #(
   parameter int CW = 3,
   parameter int SW = 2
);
   logic          alarm_match;
   logic          alarmon;
   logic [2:0]    day;
   logic          snooze;
   logic          dismiss;
   logic          buzz;
   logic          snoozing;
   logic [CW-1:0] secs_left;
   logic [SW-1:0] snooze_used;

   modport master (
      output alarm_match, alarmon, day, snooze, dismiss,
      input  buzz, snoozing, secs_left, snooze_used
   );

   modport slave (
      input  alarm_match, alarmon, day, snooze, dismiss,
      output buzz, snoozing, secs_left, snooze_used
   );
endinterface
`default_nettype wire

// File: rtl/alarm_snooze_ctrl_sec_downcounter.sv
`default_nettype none
// ============================================================================
// Module  : sec_downcounter
// Brief   : Loadable seconds down-counter that saturates at zero.
// Revision: 1.0 - initial release
// ============================================================================
module sec_downcounter #(
   parameter int WIDTH = 3
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             load,
   input  wire logic [WIDTH-1:0] value,
   input  wire logic             en,
   output logic      [WIDTH-1:0] count,
   output logic                  zero
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= value;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign count = r_count;
   assign zero  = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/alarm_snooze_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alarm_snooze_ctrl
// Brief   : Turns the raw alarm minute-match into buzzer drive with snooze,
//           dismiss and ring timeout. Clocked at 1 Hz.
//           Define WEEKEND_SKIP_EN to suppress new alarms on Sat/Sun.
// Revision: 1.0 - initial release
// ============================================================================
module alarm_snooze_ctrl
   import alarm_pkg::*;
#(
   parameter int SNOOZE_SEC = 300,
   parameter int RING_SEC   = 120,
   parameter int MAX_SNOOZE = 3
) (
   input wire logic           clk,
   input wire logic           rst,
   alarm_snooze_ctrl_if.slave bus
);
   localparam int CW = min1($clog2(SNOOZE_SEC + 1));
   localparam int SW = min1($clog2(MAX_SNOOZE + 1));
   localparam int RW = min1($clog2(RING_SEC));

   localparam logic [CW-1:0] c_snooze_load = CW'(SNOOZE_SEC - 1);
   localparam logic [RW-1:0] c_ring_last   = RW'(RING_SEC - 1);
   localparam logic [SW-1:0] c_max_snooze  = SW'(MAX_SNOOZE);

   alarm_state_t  r_state;
   logic [RW-1:0] r_ring_t;
   logic [SW-1:0] r_used;
   logic          r_buzz;
   logic          r_snoozing;

   logic          w_day_ok;
   logic          w_snz_take;
   logic          w_cnt_load;
   logic [CW-1:0] w_cnt_value;
   logic [CW-1:0] w_cnt;
   logic          w_cnt_zero;

`ifdef WEEKEND_SKIP_EN
   assign w_day_ok = (bus.day != DAY_SUN) && (bus.day != DAY_SAT);
`else
   logic w_unused_day;
   assign w_day_ok     = 1'b1;
   assign w_unused_day = ^bus.day;
`endif

   assign w_snz_take  = bus.alarmon && (r_state == RING) && !bus.dismiss &&
                        bus.snooze && (r_used < c_max_snooze);
   // Disabling the alarm also clears the snooze timer by loading zero.
   assign w_cnt_load  = !bus.alarmon || w_snz_take;
   assign w_cnt_value = bus.alarmon ? c_snooze_load : '0;

   sec_downcounter #(
      .WIDTH (CW)
   ) u_snooze_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (w_cnt_load),
      .value (w_cnt_value),
      .en    (r_state == SNOOZE),
      .count (w_cnt),
      .zero  (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst || !bus.alarmon) begin
         r_state    <= IDLE;
         r_ring_t   <= '0;
         r_used     <= '0;
         r_buzz     <= 1'b0;
         r_snoozing <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.alarm_match && w_day_ok) begin
                  r_state  <= RING;
                  r_ring_t <= '0;
                  r_used   <= '0;
                  r_buzz   <= 1'b1;
               end
            end
            RING: begin
               if (r_ring_t != c_ring_last) r_ring_t <= r_ring_t + RW'(1);
               if (bus.dismiss) begin
                  r_state <= DONE;
                  r_buzz  <= 1'b0;
               end else if (w_snz_take) begin
                  r_state    <= SNOOZE;
                  r_used     <= r_used + SW'(1);
                  r_buzz     <= 1'b0;
                  r_snoozing <= 1'b1;
               end else if (r_ring_t == c_ring_last) begin
                  r_state <= DONE;
                  r_buzz  <= 1'b0;
               end
            end
            SNOOZE: begin
               if (bus.dismiss) begin
                  r_state    <= DONE;
                  r_snoozing <= 1'b0;
               end else if (w_cnt_zero) begin
                  r_state    <= RING;
                  r_ring_t   <= '0;
                  r_buzz     <= 1'b1;
                  r_snoozing <= 1'b0;
               end
            end
            default: begin
               // DONE holds until the matching minute ends, so no re-trigger.
               if (!bus.alarm_match) r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.buzz        = r_buzz;
   assign bus.snoozing    = r_snoozing;
   assign bus.secs_left   = r_snoozing ? w_cnt : '0;
   assign bus.snooze_used = r_used;
endmodule
`default_nettype wire

// File: tb/tb_alarm_snooze_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alarm_snooze_ctrl
// Brief   : Directed self-checking bench for alarm_snooze_ctrl
//           (SNOOZE_SEC=5, RING_SEC=4, MAX_SNOOZE=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_alarm_snooze_ctrl;
   import alarm_pkg::*;

   localparam int SNOOZE_SEC = 5;
   localparam int RING_SEC   = 4;
   localparam int MAX_SNOOZE = 2;
   localparam int CW = 3;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   alarm_snooze_ctrl_if #(.CW(CW), .SW(SW)) bus ();

   alarm_snooze_ctrl #(
      .SNOOZE_SEC (SNOOZE_SEC),
      .RING_SEC   (RING_SEC),
      .MAX_SNOOZE (MAX_SNOOZE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic b, input logic s,
                          input logic [31:0] secs, input logic [31:0] used);
      chk({tag, ".buzz"}, 32'(bus.buzz), 32'(b));
      chk({tag, ".snoozing"}, 32'(bus.snoozing), 32'(s));
      chk({tag, ".secs_left"}, 32'(bus.secs_left), secs);
      chk({tag, ".snooze_used"}, 32'(bus.snooze_used), used);
   endtask

   initial begin
      rst             = 1'b1;
      bus.alarm_match = 1'b0;
      bus.alarmon     = 1'b1;
      bus.day         = 3'd2;
      bus.snooze      = 1'b0;
      bus.dismiss     = 1'b0;
      tick(2);
      chk_out("reset", 1'b0, 1'b0, 0, 0);
      chk("reset.state", 32'(dut.r_state), 32'(IDLE));
      rst = 1'b0;
      tick(1);

      // Untouched ring: buzz exactly 4 cycles, then DONE while match persists
      bus.alarm_match = 1'b1;
      for (int i = 0; i < RING_SEC; i++) begin
         tick(1);
         chk($sformatf("timeout.ring%0d", i), 32'(bus.buzz), 32'd1);
      end
      tick(1);
      chk("timeout.off", 32'(bus.buzz), 32'd0);
      chk("timeout.state", 32'(dut.r_state), 32'(DONE));
      tick(3);
      chk("timeout.noretrig", 32'(bus.buzz), 32'd0);
      bus.alarm_match = 1'b0;
      tick(1);
      chk("timeout.idle", 32'(dut.r_state), 32'(IDLE));

      // Single snooze and countdown
      bus.alarm_match = 1'b1;
      tick(1);
      chk_out("snz.ring", 1'b1, 1'b0, 0, 0);
      bus.snooze = 1'b1;
      tick(1);
      bus.snooze = 1'b0;
      chk_out("snz.s4", 1'b0, 1'b1, 4, 1);
      for (int s = 3; s >= 0; s--) begin
         tick(1);
         chk($sformatf("snz.secs%0d", s), 32'(bus.secs_left), 32'(s));
      end
      tick(1);
      chk_out("snz.rering", 1'b1, 1'b0, 0, 1);

      // Second snooze consumes the last allowance; third press is ignored
      bus.snooze = 1'b1;
      tick(1);
      bus.snooze = 1'b0;
      chk_out("exh.snz2", 1'b0, 1'b1, 4, 2);
      tick(5);
      chk_out("exh.rering", 1'b1, 1'b0, 0, 2);
      bus.snooze = 1'b1;
      for (int i = 0; i < RING_SEC - 1; i++) begin
         tick(1);
         chk_out($sformatf("exh.ignored%0d", i), 1'b1, 1'b0, 0, 2);
      end
      tick(1);
      chk_out("exh.timeout", 1'b0, 1'b0, 0, 2);
      bus.snooze      = 1'b0;
      bus.alarm_match = 1'b0;
      tick(1);
      chk("exh.idle_used", 32'(bus.snooze_used), 32'd2);

      // Snooze and dismiss together: dismiss wins
      bus.alarm_match = 1'b1;
      tick(1);
      chk_out("sim.ring", 1'b1, 1'b0, 0, 0);
      bus.snooze  = 1'b1;
      bus.dismiss = 1'b1;
      tick(1);
      bus.snooze  = 1'b0;
      bus.dismiss = 1'b0;
      chk_out("sim.done", 1'b0, 1'b0, 0, 0);
      chk("sim.state", 32'(dut.r_state), 32'(DONE));
      bus.alarm_match = 1'b0;
      tick(1);

      // Alarm disabled mid-snooze
      bus.alarm_match = 1'b1;
      tick(1);
      bus.snooze = 1'b1;
      tick(1);
      bus.snooze = 1'b0;
      tick(1);
      chk_out("off.snz", 1'b0, 1'b1, 3, 1);
      bus.alarmon = 1'b0;
      tick(1);
      chk_out("off.idle", 1'b0, 1'b0, 0, 0);
      chk("off.state", 32'(dut.r_state), 32'(IDLE));
      bus.alarmon = 1'b1;
      tick(1);
      chk("off.rering", 32'(bus.buzz), 32'd1);
      bus.alarm_match = 1'b0;
      bus.alarmon     = 1'b0;
      tick(1);
      bus.alarmon = 1'b1;

      // Saturday start
      bus.day         = 3'd6;
      bus.alarm_match = 1'b1;
      tick(1);
`ifdef WEEKEND_SKIP_EN
      chk("wkend.skip0", 32'(bus.buzz), 32'd0);
      tick(2);
      chk("wkend.skip1", 32'(bus.buzz), 32'd0);
`else
      chk("wkend.ring", 32'(bus.buzz), 32'd1);
`endif
      bus.alarm_match = 1'b0;
      bus.alarmon     = 1'b0;
      tick(1);
      bus.alarmon = 1'b1;
      bus.day     = 3'd2;

      // Reset in the middle of a snooze
      bus.alarm_match = 1'b1;
      tick(1);
      bus.snooze = 1'b1;
      tick(1);
      bus.snooze = 1'b0;
      tick(1);
      chk_out("rst.snz", 1'b0, 1'b1, 3, 1);
      rst = 1'b1;
      tick(1);
      chk_out("rst.clear", 1'b0, 1'b0, 0, 0);
      chk("rst.state", 32'(dut.r_state), 32'(IDLE));
      rst = 1'b0;
      tick(1);
      chk("rst.rering", 32'(bus.buzz), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
